// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared fetch constants and the queued {pc, inst} entry type
package inst_fetch_queue_pkg;

    localparam logic [31:0] INST_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_BYTES    = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// rtl/inst_fetch_queue_sync_fifo.sv - generic DEPTH x WIDTH circular FIFO with push/pop/flush and count
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop & (count != '0) & ~flush;
        do_push = push & ((count < FULL_COUNT) | do_pop) & ~flush;
    end

    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch PC owner, InstMemory read driver and prefetch queue toward decode
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = INST_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              imem_addr,
    output logic                     imem_read,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]  fetch_pc;
    logic         issue;
    logic         pop;
    fetch_entry_t wr_entry;
    fetch_entry_t head_entry;
    logic [63:0]  head_bits;
    logic [CW-1:0] count;

    // Redirect blanks the head so decode never consumes a wrong-path instruction.
    always_comb begin
        out_valid = (count != '0) & ~redirect_valid & ~rst;
        pop       = out_valid & out_ready;
        issue     = fetch_en & ~redirect_valid & ~rst & ((count < FULL_COUNT) | pop);
    end

    assign imem_read   = issue;
    assign imem_addr   = fetch_pc;
    assign wr_entry    = '{pc: fetch_pc, inst: imem_rdata};
    assign head_entry  = fetch_entry_t'(head_bits);
    assign out_inst    = head_entry.inst;
    assign out_pc      = head_entry.pc;
    assign queue_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
        end else if (issue) begin
            fetch_pc <= fetch_pc + INST_BYTES;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (issue),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head_bits),
        .count (count)
    );

endmodule
